puc_seq: RTL and testbench
==========================

Name: puc_seq

Overview:
- Uncore power-up sequencer, directly downstream of the power-up contract unit.
- Consumes the latched contract vector, which is active-high with one bit per power domain.
- Brings up each contracted domain in ascending index order using an enable/acknowledge handshake with a fixed settle interval, then reports ready.
- Any handshake violation gives a sticky fault and full power-down.

Parameters:
N_PUC, 2, number of contract bits and power domains (>=1)
SETTLE_CYCLES, 4, cycles a domain must hold ack before the next domain starts (>=1)
TIMEOUT_CYCLES, 16, max cycles waiting for ack after enable (>=1)

Ports:
clk_i  input  1  clock
reset_i  input  1  reset; one clock, synchronous, active-high
puc_i  input  N_PUC  power-up contract vector, active-high, stable once reset deasserts
pwr_ack_i  input  N_PUC  per-domain power-good acknowledge
pwr_en_o  output  N_PUC  per-domain power enable, registered
busy_o  output  1  sequence in progress
ready_o  output  1  all contracted domains up
fault_o  output  1  sticky sequencing fault
fault_idx_o  output  max(1,$clog2(N_PUC))  index of the faulting domain

Behaviour:
- All outputs are registered.
- Reset value of every output is 0. State resets to IDLE, the domain index to 0 and the counter to 0.
- Reset asserted in any state returns to reset values on the next edge. This includes dropping every pwr_en_o.
- Internal widths: domain index is $clog2(N_PUC+1) bits. Counter is $clog2(max(TIMEOUT_CYCLES,SETTLE_CYCLES)+1) bits.
- IDLE: at the first edge with reset_i low, capture puc_i into cap_q, set busy_o=1 and go to SCAN. Later changes on puc_i are ignored until the next reset.
- SCAN, idx==N_PUC: go to DONE.
- SCAN, cap_q[idx]==0: idx++ and stay in SCAN. Each skipped domain costs one cycle.
- SCAN, cap_q[idx]==1: set pwr_en_o[idx]=1, clear the counter, go to WAIT_ACK.
- WAIT_ACK, pwr_ack_i[idx]==1: clear the counter, go to SETTLE.
- WAIT_ACK, no ack and counter==TIMEOUT_CYCLES-1: go to FAULT. Otherwise counter++.
- WAIT_ACK duration: exactly TIMEOUT_CYCLES evaluations before timeout.
- SETTLE, pwr_ack_i[idx]==0: go to FAULT.
- SETTLE, counter==SETTLE_CYCLES-1: idx++ and go to SCAN. Otherwise counter++.
- DONE: ready_o=1, busy_o=0, enables held.
- DONE, any domain with pwr_en_o[i]==1 and pwr_ack_i[i]==0: go to FAULT, with fault_idx_o = lowest such i.
- Domain already up (any active state past SETTLE): loss of ack on that domain faults, with fault_idx_o = lowest such index.
- FAULT entry from WAIT_ACK or SETTLE: fault_idx_o=idx.
- FAULT entry, all cases: pwr_en_o=0, ready_o=0, busy_o=0 and fault_o=1 on the same edge.
- FAULT exit: none; the state is left only by reset.
- Acks on domains whose enable is low are ignored. Early or spurious acks never fault.
- An ack already high when WAIT_ACK is entered is accepted on the first WAIT_ACK evaluation.
- cap_q all zeros: SCAN walks all indices and reaches DONE with no enable asserted.
- Simultaneous timeout and ack on the same edge: ack wins.

Test Plan:
- Defaults, puc_i=2'b11, pwr_ack_i tied 2'b11:
  - First low edge is edge 1.
  - pwr_en_o[0] rises after edge 2 and pwr_en_o[1] after edge 8.
  - ready_o=1 and busy_o=0 after edge 14; fault_o stays 0.
- puc_i=2'b10, pwr_ack_i=0:
  - pwr_en_o=2'b10 after edge 3.
  - After 16 WAIT_ACK cycles: fault_o=1, fault_idx_o=1, pwr_en_o=0.
  - Holds indefinitely until reset.
- puc_i=2'b11, ack[0] follows en[0] with 3-cycle delay; drop ack[0] for one cycle during domain 1 SETTLE:
  - fault_o=1, fault_idx_o=0, all enables low on the next edge.
- puc_i=2'b00:
  - ready_o=1 after edge 4 (IDLE, SCAN, SCAN, SCAN->DONE).
  - pwr_en_o stays 0 throughout.
- Ack arrives exactly on the 16th WAIT_ACK evaluation:
  - No fault; enters SETTLE.
- Reset pulse during domain 1 WAIT_ACK, and again while in FAULT:
  - All outputs return to 0 on the next edge.
  - A fresh sequence restarts and completes, with new puc_i captured.

Source files
------------

// File: rtl/puc_seq_if.sv
// Bus between the power-up contract unit / power domains and the uncore
// power-up sequencer. The sequencer sits on the slave side. The master side
// drives the contract vector and the acknowledges.
interface puc_seq_if #(
    parameter int N_PUC = 2
);
    localparam int FI_W = (N_PUC > 1) ? $clog2(N_PUC) : 1;

    logic [N_PUC-1:0] puc_i;        // latched power-up contract, one bit per domain
    logic [N_PUC-1:0] pwr_ack_i;    // per-domain power-good
    logic [N_PUC-1:0] pwr_en_o;     // per-domain power enable
    logic             busy_o;       // sequence in progress
    logic             ready_o;      // every contracted domain is up
    logic             fault_o;      // sticky sequencing fault
    logic [FI_W-1:0]  fault_idx_o;  // domain that caused the fault

    modport slave (
        input  puc_i, pwr_ack_i,
        output pwr_en_o, busy_o, ready_o, fault_o, fault_idx_o
    );

    modport master (
        output puc_i, pwr_ack_i,
        input  pwr_en_o, busy_o, ready_o, fault_o, fault_idx_o
    );
endinterface

// File: rtl/puc_seq.sv
// Uncore power-up sequencer. Captures the contract vector once after reset
// and then powers up each contracted domain in ascending order. Each domain
// raises its enable, waits for ack (bounded by a timeout) and then needs ack
// held for a settle interval before the next domain starts. Any timeout or
// loss of ack on a live domain drops every enable and latches a fault
// that only reset clears.
module puc_seq #(
    parameter int N_PUC          = 2,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic     clk_i,
    input  logic     reset_i,
    puc_seq_if.slave bus
);
    localparam int FI_W    = (N_PUC > 1) ? $clog2(N_PUC) : 1;
    localparam int IDX_W   = $clog2(N_PUC + 1);
    localparam int CNT_MAX = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [IDX_W-1:0] IDX_END = IDX_W'(N_PUC);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] ST_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_WAIT_ACK,
        S_SETTLE,
        S_DONE,
        S_FAULT
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_PUC-1:0] cap_q, cap_d;
    logic [N_PUC-1:0] en_q, en_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;
    logic             fault_q, fault_d;
    logic [FI_W-1:0]  fault_idx_q, fault_idx_d;

    // Per-cycle helpers and fault decision inputs.
    logic [N_PUC-1:0] sel;        // one-hot of the current domain, zero once idx passes the end
    logic             cur_cap;
    logic             cur_ack;
    logic             lost;       // a domain that finished settling has lost its ack
    logic [FI_W-1:0]  lost_idx;
    logic             go_fault;
    logic [FI_W-1:0]  fault_at;

    // State register: synchronous reset returns every output and all state to zero.
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (reset_i) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            cap_q       <= '0;
            en_q        <= '0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
            fault_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            cap_q       <= cap_d;
            en_q        <= en_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
            fault_q     <= fault_d;
            fault_idx_q <= fault_idx_d;
        end
    end

    // Next-state and next-output logic; every fault path funnels through one shutdown block.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        cap_d       = cap_q;
        en_d        = en_q;
        busy_d      = busy_q;
        ready_d     = ready_q;
        fault_d     = fault_q;
        fault_idx_d = fault_idx_q;
        go_fault    = 1'b0;
        fault_at    = '0;

        sel     = N_PUC'(1) << idx_q;
        cur_cap = |(cap_q & sel);
        cur_ack = |(bus.pwr_ack_i & sel);

        // Domains below idx have completed settle; scanning downwards leaves the lowest.
        lost     = 1'b0;
        lost_idx = '0;
        for (int i = N_PUC - 1; i >= 0; i--) begin
            if (en_q[i] && !bus.pwr_ack_i[i] && (i < int'(idx_q))) begin
                lost     = 1'b1;
                lost_idx = FI_W'(i);
            end
        end

        unique case (state_q)
            S_IDLE: begin
                cap_d   = bus.puc_i;
                busy_d  = 1'b1;
                state_d = S_SCAN;
            end
            S_SCAN: begin
                if (lost) begin
                    go_fault = 1'b1;
                    fault_at = lost_idx;
                end else if (idx_q == IDX_END) begin
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_DONE;
                end else if (cur_cap) begin
                    en_d    = en_q | sel;
                    cnt_d   = '0;
                    state_d = S_WAIT_ACK;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_WAIT_ACK: begin
                // Ack is tested before the timeout so a last-cycle ack still counts.
                if (lost) begin
                    go_fault = 1'b1;
                    fault_at = lost_idx;
                end else if (cur_ack) begin
                    cnt_d   = '0;
                    state_d = S_SETTLE;
                end else if (cnt_q == TO_LAST) begin
                    go_fault = 1'b1;
                    fault_at = FI_W'(idx_q);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_SETTLE: begin
                if (lost) begin
                    go_fault = 1'b1;
                    fault_at = lost_idx;
                end else if (!cur_ack) begin
                    go_fault = 1'b1;
                    fault_at = FI_W'(idx_q);
                end else if (cnt_q == ST_LAST) begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_SCAN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                if (lost) begin
                    go_fault = 1'b1;
                    fault_at = lost_idx;
                end
            end
            S_FAULT: begin
                // Terminal until reset.
            end
            default: begin
                state_d = S_FAULT;
            end
        endcase

        if (go_fault) begin
            state_d     = S_FAULT;
            en_d        = '0;
            ready_d     = 1'b0;
            busy_d      = 1'b0;
            fault_d     = 1'b1;
            fault_idx_d = fault_at;
        end
    end

    assign bus.pwr_en_o    = en_q;
    assign bus.busy_o      = busy_q;
    assign bus.ready_o     = ready_q;
    assign bus.fault_o     = fault_q;
    assign bus.fault_idx_o = fault_idx_q;
endmodule

// File: tb/tb_puc_seq.sv
// Self-checking bench for puc_seq. Each scenario fixes the contract vector
// and the edge after which each domain's ack goes high (optionally with a
// one-cycle drop). The expected output trace is derived from a timeline:
// when each enable rises, when each ack is accepted, and when ready or the
// fault arrives.
module tb_puc_seq;
    localparam int N_PUC   = 2;
    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 16;
    localparam int NEVER   = 100000;

    logic clk_i   = 1'b0;
    logic reset_i = 1'b1;

    puc_seq_if #(.N_PUC(N_PUC)) bus ();

    puc_seq #(
        .N_PUC          (N_PUC),
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    always #5 clk_i = ~clk_i;

    int n_vec  = 0;
    int n_miss = 0;

    // Stimulus schedule: ack[i] is high at every edge numbered above ack_at[i],
    // except that drop_dom reads low at edge drop_edge (0 = no drop).
    int ack_at [N_PUC];
    int drop_dom;
    int drop_edge;

    // Expected timeline, edges counted from the first edge with reset low.
    int m_en_edge  [N_PUC];   // edge at which enable rises (0 = never)
    int m_acc_edge [N_PUC];   // edge at which ack is accepted (0 = never)
    int m_fault_edge;
    int m_fault_idx;
    int m_done_edge;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N_PUC-1:0] ack_for(input int k);
        logic [N_PUC-1:0] a;
        for (int i = 0; i < N_PUC; i++)
            a[i] = (k > ack_at[i]) && !(drop_edge != 0 && i == drop_dom && k == drop_edge);
        return a;
    endfunction

    // Timeline: capture at edge 1, one edge per scanned index; a contracted
    // domain enables on its scan edge, then ack is accepted on the first of
    // the next TIMEOUT edges where it is high; SETTLE edges follow.
    task automatic build_model(input logic [N_PUC-1:0] puc);
        int t;
        int w;
        t            = 1;
        m_fault_edge = NEVER;
        m_fault_idx  = 0;
        m_done_edge  = NEVER;
        for (int i = 0; i < N_PUC; i++) begin
            m_en_edge[i]  = 0;
            m_acc_edge[i] = 0;
        end
        for (int i = 0; i < N_PUC; i++) begin
            if (m_fault_edge == NEVER) begin
                if (!puc[i]) begin
                    t = t + 1;
                end else begin
                    m_en_edge[i] = t + 1;
                    w = (ack_at[i] + 1 > t + 2) ? ack_at[i] + 1 : t + 2;
                    if (w > m_en_edge[i] + TIMEOUT) begin
                        m_fault_edge = m_en_edge[i] + TIMEOUT;
                        m_fault_idx  = i;
                    end else begin
                        m_acc_edge[i] = w;
                        t = w + SETTLE;
                    end
                end
            end
        end
        if (m_fault_edge == NEVER) m_done_edge = t + 1;
        // Once accepted, a domain needs ack on every later edge.
        if (drop_edge != 0 && m_acc_edge[drop_dom] != 0 &&
            drop_edge > m_acc_edge[drop_dom] && drop_edge <= m_fault_edge) begin
            m_fault_edge = drop_edge;
            m_fault_idx  = drop_dom;
        end
    endtask

    // Reset pulse, reset-value check, then n_edges checked edges. Called on a negedge.
    task automatic run_seq(input logic [N_PUC-1:0] puc, input int n_edges, input string name);
        logic [N_PUC-1:0] exp_en;
        int end_busy;
        reset_i       = 1'b1;
        bus.puc_i     = puc;
        bus.pwr_ack_i = N_PUC'($urandom);
        @(negedge clk_i);
        check({name, " rst en"},    32'(bus.pwr_en_o),    32'd0);
        check({name, " rst busy"},  32'(bus.busy_o),      32'd0);
        check({name, " rst ready"}, 32'(bus.ready_o),     32'd0);
        check({name, " rst fault"}, 32'(bus.fault_o),     32'd0);
        check({name, " rst fidx"},  32'(bus.fault_idx_o), 32'd0);
        reset_i       = 1'b0;
        bus.pwr_ack_i = ack_for(1);
        end_busy = (m_done_edge < m_fault_edge) ? m_done_edge : m_fault_edge;
        for (int k = 1; k <= n_edges; k++) begin
            @(negedge clk_i);
            for (int i = 0; i < N_PUC; i++)
                exp_en[i] = (m_en_edge[i] != 0) && (k >= m_en_edge[i]) && (k < m_fault_edge);
            check($sformatf("%s en@%0d", name, k),    32'(bus.pwr_en_o), 32'(exp_en));
            check($sformatf("%s busy@%0d", name, k),  32'(bus.busy_o),   32'(k < end_busy));
            check($sformatf("%s ready@%0d", name, k), 32'(bus.ready_o),
                  32'((k >= m_done_edge) && (k < m_fault_edge)));
            check($sformatf("%s fault@%0d", name, k), 32'(bus.fault_o),  32'(k >= m_fault_edge));
            check($sformatf("%s fidx@%0d", name, k),  32'(bus.fault_idx_o),
                  (k >= m_fault_edge) ? 32'(m_fault_idx) : 32'd0);
            // The captured contract must not follow later puc_i changes.
            if (k == 1) bus.puc_i = N_PUC'($urandom);
            bus.pwr_ack_i = ack_for(k + 1);
        end
    endtask

    initial begin
        int last;
        logic [N_PUC-1:0] puc;
        bus.puc_i     = '0;
        bus.pwr_ack_i = '0;
        drop_dom      = 0;
        drop_edge     = 0;
        @(negedge clk_i);

        // Both domains, acks tied high: en0 at 2, en1 at 8, ready at 14.
        ack_at[0] = 0; ack_at[1] = 0;
        build_model(2'b11);
        run_seq(2'b11, 18, "all_up");

        // Domain 1 only, never acked: enable at 3, timeout fault at 19, held.
        ack_at[0] = NEVER; ack_at[1] = NEVER;
        build_model(2'b10);
        run_seq(2'b10, 40, "timeout");

        // Delayed ack on domain 0, one-cycle drop during domain 1 settle.
        ack_at[0] = 5; ack_at[1] = 0;
        drop_dom = 0; drop_edge = 14;
        build_model(2'b11);
        run_seq(2'b11, 20, "drop");
        drop_edge = 0;

        // Empty contract: ready at 4, no enables.
        ack_at[0] = 0; ack_at[1] = 0;
        build_model(2'b00);
        run_seq(2'b00, 8, "empty");

        // Ack on the 16th wait evaluation is accepted; one later times out.
        ack_at[0] = 17; ack_at[1] = NEVER;
        build_model(2'b01);
        run_seq(2'b01, 26, "ack_last");
        ack_at[0] = 18;
        build_model(2'b01);
        run_seq(2'b01, 24, "ack_late");

        // Abort during domain 1 wait; the next run's reset check covers it.
        ack_at[0] = 0; ack_at[1] = NEVER;
        build_model(2'b11);
        run_seq(2'b11, 11, "abort_wait");
        ack_at[0] = 0; ack_at[1] = 0;
        build_model(2'b01);
        run_seq(2'b01, 10, "restart1");

        // Sit in FAULT, then reset and complete with a new contract.
        ack_at[0] = NEVER; ack_at[1] = 0;
        build_model(2'b01);
        run_seq(2'b01, 25, "abort_fault");
        ack_at[0] = 0; ack_at[1] = 3;
        build_model(2'b10);
        run_seq(2'b10, 12, "restart2");

        // Randomized contracts, ack times and drops.
        for (int s = 0; s < 24; s++) begin
            puc = N_PUC'($urandom);
            for (int i = 0; i < N_PUC; i++)
                ack_at[i] = ($urandom_range(0, 5) == 0) ? NEVER : int'($urandom_range(0, 30));
            drop_edge = 0;
            drop_dom  = int'($urandom_range(0, N_PUC - 1));
            build_model(puc);
            if ($urandom_range(0, 1) == 1 && m_acc_edge[drop_dom] != 0) begin
                drop_edge = m_acc_edge[drop_dom] + 1 + int'($urandom_range(0, 12));
                build_model(puc);
            end
            last = (m_done_edge < m_fault_edge) ? m_done_edge : m_fault_edge;
            run_seq(puc, last + 4, $sformatf("rnd%0d", s));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
